// File: rtl/multi_cycle_seq_pkg.sv
// Shared definitions for the multi-cycle main-control sequencer: state codes,
// PC-source encodings (also used by the datapath PC mux) and the latched control bundle.
package multi_cycle_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  typedef struct packed {
    logic regwr;
    logic memtoreg;
    logic memwr;
    logic branch;
    logic jump;
    logic link;
  } ctrl_t;

  function automatic logic is_mem_op(input ctrl_t c);
    return c.memtoreg | c.memwr;
  endfunction

endpackage

// File: rtl/multi_cycle_seq_wait_timer.sv
// Counts stalled request cycles; 'expired' is high once the count has reached TIMEOUT.
module wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise count up and hold at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/multi_cycle_seq.sv
// Main-control FSM sequencing IF/ID/EX/MEM/WB with req/ready memories,
// a stall timeout into a sticky error state, and a retired-instruction counter.
module multi_cycle_seq
  import multi_cycle_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             dec_regwr,
  input  logic             dec_memtoreg,
  input  logic             dec_memwr,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_link,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             ir_wr,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             bus_err
);

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  ctrl_t             dec_s;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              bus_err_q, bus_err_d;
  logic              retire_s;
  logic              stall_s;
  logic              expired_s;

  assign dec_s = '{regwr: dec_regwr, memtoreg: dec_memtoreg, memwr: dec_memwr,
                   branch: dec_branch, jump: dec_jump, link: dec_link};

  // A request is stalled when its own ready is low; ready for the other memory is ignored.
  assign stall_s = ((state_q == ST_IF)  && !imem_ready) ||
                   ((state_q == ST_MEM) && !dmem_ready);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!stall_s),
    .count_en (stall_s),
    .expired  (expired_s)
  );

  // next state, control latch and per-cycle strobes
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    imem_req = 1'b0;
    ir_wr    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_wr    = 1'b0;
    pc_src   = PC_SRC_SEQ;
    retire_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_IF;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_wr   = 1'b1;
          state_d = ST_ID;
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_ID: begin
        ctrl_d  = dec_s;
        state_d = ST_EX;
      end
      ST_EX: begin
        if (ctrl_q.jump && !ctrl_q.link) begin
          pc_wr    = 1'b1;
          pc_src   = PC_SRC_JMP;
          retire_s = 1'b1;
        end else if (ctrl_q.jump || (ctrl_q.branch && ctrl_q.link)) begin
          // linking jumps/branches write the return address in WB
          state_d = ST_WB;
        end else if (ctrl_q.branch) begin
          pc_wr    = 1'b1;
          pc_src   = alu_zero ? PC_SRC_BR : PC_SRC_SEQ;
          retire_s = 1'b1;
        end else if (is_mem_op(ctrl_q)) begin
          state_d = ST_MEM;
        end else if (ctrl_q.regwr) begin
          state_d = ST_WB;
        end else begin
          pc_wr    = 1'b1;
          pc_src   = PC_SRC_SEQ;
          retire_s = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl_q.memwr;
        if (dmem_ready) begin
          if (ctrl_q.memwr) begin
            pc_wr    = 1'b1;
            retire_s = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we    = 1'b1;
        pc_wr    = 1'b1;
        pc_src   = ctrl_q.link ? PC_SRC_JMP : PC_SRC_SEQ;
        retire_s = 1'b1;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (retire_s) begin
      state_d = run ? ST_IF : ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  assign retired_d = retire_s ? (retired_q + CNT_W'(1)) : retired_q;
  assign bus_err_d = bus_err_q | (state_d == ST_ERR);

  // state, control latch, retire counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      retired_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      retired_q <= retired_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multi_cycle_seq.sv
// Directed bench for multi_cycle_seq: instruction-level trace model feeding a per-cycle
// compare process, plus literal checks on cycle counts, counter wrap and error/reset behaviour.
module tb_multi_cycle_seq;

  localparam logic [2:0] S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
                         S_MEM  = 3'd4, S_WB = 3'd5, S_ERR = 3'd6;

  // control bundle bits: [5]regwr [4]memtoreg [3]memwr [2]branch [1]jump [0]link
  localparam logic [5:0] I_ADD = 6'b100000, I_LW  = 6'b110000, I_SW  = 6'b001000,
                         I_BEQ = 6'b000100, I_JAL = 6'b100011, I_J   = 6'b000010,
                         I_BAL = 6'b100101, I_NOP = 6'b000000;

  logic       clk = 1'b0;
  logic       rst, run, imem_ready, dmem_ready, alu_zero;
  logic       dec_regwr, dec_memtoreg, dec_memwr, dec_branch, dec_jump, dec_link;
  logic       imem_req, ir_wr, dmem_req, dmem_we, rf_we, pc_wr, bus_err;
  logic [1:0] pc_src;
  logic [2:0] dut_state;
  logic [3:0] retired;

  typedef struct {
    logic [2:0] st;
    logic [5:0] strb;   // imem_req, ir_wr, dmem_req, dmem_we, rf_we, pc_wr
    logic [1:0] src;
    logic [3:0] ret;
    logic       berr;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         ncyc  = 0;
  logic [3:0] m_ret = 4'd0;
  logic       m_berr = 1'b0;

  multi_cycle_seq #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dec_regwr(dec_regwr), .dec_memtoreg(dec_memtoreg), .dec_memwr(dec_memwr),
    .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_link(dec_link), .alu_zero(alu_zero),
    .imem_req(imem_req), .ir_wr(ir_wr), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_wr(pc_wr), .pc_src(pc_src), .state(dut_state),
    .retired(retired), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic [5:0] strb,
                              input logic [1:0] src, input string tag);
    exp_t e;
    e.st = st; e.strb = strb; e.src = src; e.ret = m_ret; e.berr = m_berr; e.tag = tag;
    return e;
  endfunction

  // one compare per driven cycle, sampled mid-low-phase
  always @(negedge clk) begin
    exp_t e;
    logic [15:0] got, want;
    #2;
    if (exp_q.size() != 0) begin
      e    = exp_q.pop_front();
      got  = {dut_state, imem_req, ir_wr, dmem_req, dmem_we, rf_we, pc_wr, pc_src, retired, bus_err};
      want = {e.st, e.strb, e.src, e.ret, e.berr};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s @%0t: got st=%0d strb=%b src=%0d ret=%0d err=%b want st=%0d strb=%b src=%0d ret=%0d err=%b",
                 e.tag, $time, got[15:13], got[12:7], got[6:5], got[4:1], got[0],
                 e.st, e.strb, e.src, e.ret, e.berr);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input logic r_rst, input logic r_run, input logic r_ir, input logic r_dr,
                     input logic r_z, input logic [5:0] dec, input exp_t e);
    @(negedge clk);
    rst = r_rst; run = r_run; imem_ready = r_ir; dmem_ready = r_dr; alu_zero = r_z;
    {dec_regwr, dec_memtoreg, dec_memwr, dec_branch, dec_jump, dec_link} = dec;
    exp_q.push_back(e);
    ncyc++;
  endtask

  task automatic idle(input logic r, input int n, input string tag);
    for (int k = 0; k < n; k++) cyc(1'b0, r, 1'b1, 1'b1, 1'b0, 6'h3f, mk(S_IDLE, 6'b0, 2'd0, tag));
  endtask

  // Expected trace of one instruction from its first IF cycle to retire.
  // Readies for the other memory are held high to show they are ignored.
  task automatic do_instr(input string tag, input logic [5:0] c, input logic z, input int iw,
                          input int dw, input logic rn, output int n);
    logic [5:0] nc;
    logic regwr, ld, st, br, jp, lk;
    int start;
    nc = ~c; start = ncyc;
    {regwr, ld, st, br, jp, lk} = c;
    for (int k = 0; k < iw; k++) cyc(1'b0, rn, 1'b0, 1'b1, ~z, nc, mk(S_IF, 6'b100000, 2'd0, tag));
    cyc(1'b0, rn, 1'b1, 1'b1, ~z, nc, mk(S_IF, 6'b110000, 2'd0, tag));
    cyc(1'b0, rn, 1'b1, 1'b1, ~z, c,  mk(S_ID, 6'b000000, 2'd0, tag));
    if (jp && !lk) begin
      cyc(1'b0, rn, 1'b1, 1'b1, z, nc, mk(S_EX, 6'b000001, 2'd2, tag));
      m_ret = m_ret + 4'd1;
    end else if (jp || (br && lk)) begin
      cyc(1'b0, rn, 1'b1, 1'b1, z, nc, mk(S_EX, 6'b000000, 2'd0, tag));
      cyc(1'b0, rn, 1'b1, 1'b1, ~z, nc, mk(S_WB, 6'b000011, 2'd2, tag));
      m_ret = m_ret + 4'd1;
    end else if (br) begin
      cyc(1'b0, rn, 1'b1, 1'b1, z, nc, mk(S_EX, 6'b000001, z ? 2'd1 : 2'd0, tag));
      m_ret = m_ret + 4'd1;
    end else if (ld || st) begin
      cyc(1'b0, rn, 1'b1, 1'b1, z, nc, mk(S_EX, 6'b000000, 2'd0, tag));
      for (int k = 0; k < dw; k++)
        cyc(1'b0, rn, 1'b1, 1'b0, ~z, nc, mk(S_MEM, {2'b00, 1'b1, st, 2'b00}, 2'd0, tag));
      if (st) begin
        cyc(1'b0, rn, 1'b1, 1'b1, ~z, nc, mk(S_MEM, 6'b001101, 2'd0, tag));
        m_ret = m_ret + 4'd1;
      end else begin
        cyc(1'b0, rn, 1'b1, 1'b1, ~z, nc, mk(S_MEM, 6'b001000, 2'd0, tag));
        cyc(1'b0, rn, 1'b1, 1'b1, ~z, nc, mk(S_WB, 6'b000011, lk ? 2'd2 : 2'd0, tag));
        m_ret = m_ret + 4'd1;
      end
    end else if (regwr) begin
      cyc(1'b0, rn, 1'b1, 1'b1, z, nc, mk(S_EX, 6'b000000, 2'd0, tag));
      cyc(1'b0, rn, 1'b1, 1'b1, ~z, nc, mk(S_WB, 6'b000011, lk ? 2'd2 : 2'd0, tag));
      m_ret = m_ret + 4'd1;
    end else begin
      cyc(1'b0, rn, 1'b1, 1'b1, z, nc, mk(S_EX, 6'b000001, 2'd0, tag));
      m_ret = m_ret + 4'd1;
    end
    n = ncyc - start;
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
    {dec_regwr, dec_memtoreg, dec_memwr, dec_branch, dec_jump, dec_link} = 6'b0;

    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h3f, mk(S_IDLE, 6'b0, 2'd0, "reset"));
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h3f, mk(S_IDLE, 6'b0, 2'd0, "reset"));
    idle(1'b0, 2, "idle_run0");
    idle(1'b1, 1, "idle_run1");

    do_instr("add", I_ADD, 1'b0, 0, 0, 1'b1, n); #3; chk("add_cycles", 8'(n), 8'd4);
    do_instr("lw",  I_LW,  1'b0, 2, 3, 1'b1, n); #3; chk("lw_cycles",  8'(n), 8'd10);
    do_instr("sw",  I_SW,  1'b1, 1, 0, 1'b1, n); #3; chk("sw_cycles",  8'(n), 8'd5);
    do_instr("beq_t", I_BEQ, 1'b1, 0, 0, 1'b1, n);
    do_instr("beq_nt", I_BEQ, 1'b0, 1, 0, 1'b1, n);
    do_instr("jal", I_JAL, 1'b0, 0, 0, 1'b1, n); #3; chk("jal_cycles", 8'(n), 8'd4);
    do_instr("j",   I_J,   1'b1, 0, 0, 1'b1, n); #3; chk("j_cycles",   8'(n), 8'd3);
    do_instr("bal", I_BAL, 1'b0, 0, 0, 1'b1, n);
    do_instr("nop", I_NOP, 1'b0, 0, 0, 1'b1, n); #3; chk("nop_cycles", 8'(n), 8'd3);
    // ready on the last allowed MEM cycle, then run drops so the machine parks
    do_instr("lw_edge", I_LW, 1'b0, 0, 4, 1'b0, n);
    idle(1'b0, 3, "parked");
    #3; chk("retired_10", 8'(retired), 8'd10);
    chk("parked_no_fetch", 8'(imem_req), 8'd0);

    idle(1'b1, 1, "restart");
    for (int i = 0; i < 6; i++) do_instr("nop_wrap", I_NOP, 1'b0, 0, 0, 1'b1, n);
    do_instr("nop_wrap", I_NOP, 1'b0, 0, 0, 1'b0, n);
    idle(1'b0, 1, "wrapped");
    #3; chk("retired_wrap", 8'(retired), 8'd1);

    // data memory never answers: five MEM cycles then sticky error
    idle(1'b1, 1, "to_err");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ~I_LW, mk(S_IF, 6'b110000, 2'd0, "err"));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, I_LW,  mk(S_ID, 6'b000000, 2'd0, "err"));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ~I_LW, mk(S_EX, 6'b000000, 2'd0, "err"));
    for (int k = 0; k < 5; k++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ~I_LW, mk(S_MEM, 6'b001000, 2'd0, "err_mem"));
    m_berr = 1'b1;
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ~I_LW, mk(S_ERR, 6'b000000, 2'd0, "err_hold"));
    #3; chk("bus_err_sticky", 8'(bus_err), 8'd1);
    chk("err_state", 8'(dut_state), 8'd6);

    m_ret = 4'd0; m_berr = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h3f, mk(S_IDLE, 6'b0, 2'd0, "err_reset"));
    idle(1'b1, 1, "post_reset");
    do_instr("add2", I_ADD, 1'b0, 0, 0, 1'b1, n);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ~I_LW, mk(S_IF, 6'b110000, 2'd0, "rst_mem"));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, I_LW,  mk(S_ID, 6'b000000, 2'd0, "rst_mem"));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ~I_LW, mk(S_EX, 6'b000000, 2'd0, "rst_mem"));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ~I_LW, mk(S_MEM, 6'b001000, 2'd0, "rst_mem"));
    m_ret = 4'd0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ~I_LW, mk(S_IDLE, 6'b0, 2'd0, "rst_mid_mem"));
    #3; chk("rst_dmem_req", 8'(dmem_req), 8'd0);
    chk("rst_retired", 8'(retired), 8'd0);
    idle(1'b0, 3, "final_idle");

    repeat (2) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
